// File: rtl/twi_slave_pkg.sv
// rtl/twi_slave_pkg.sv - shared types and constants for the twi_slave I2C target
package twi_slave_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_PTR,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } state_e;

    localparam logic ACK_LVL    = 1'b0;
    localparam logic NACK_LVL   = 1'b1;
    localparam int   SYNC_DEPTH = 2;

endpackage

// File: rtl/twi_line_sync.sv
// rtl/twi_line_sync.sv - SCL/SDA synchronizer with registered edge, START and STOP pulses
module twi_line_sync
    import twi_slave_pkg::*;
(
    input  logic CLK_I,
    input  logic RST_I,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop,
    output logic o_sda
);

    logic [SYNC_DEPTH-1:0] r_scl_sync;
    logic [SYNC_DEPTH-1:0] r_sda_sync;
    logic                  r_scl_dly;
    logic                  r_sda_dly;
    logic                  r_scl_rise;
    logic                  r_scl_fall;
    logic                  r_start;
    logic                  r_stop;
    logic                  r_sda_smp;
    logic                  w_scl;
    logic                  w_sda;

    assign w_scl = r_scl_sync[SYNC_DEPTH-1];
    assign w_sda = r_sda_sync[SYNC_DEPTH-1];

    // Everything resets high so an idle bus after reset shows no edges or START.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_dly  <= 1'b1;
            r_sda_dly  <= 1'b1;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
            r_sda_smp  <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_DEPTH-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_DEPTH-2:0], i_sda};
            r_scl_dly  <= w_scl;
            r_sda_dly  <= w_sda;
            r_scl_rise <= w_scl & ~r_scl_dly;
            r_scl_fall <= ~w_scl & r_scl_dly;
            r_start    <= w_scl & r_scl_dly & ~w_sda & r_sda_dly;
            r_stop     <= w_scl & r_scl_dly & w_sda & ~r_sda_dly;
            r_sda_smp  <= w_sda;
        end
    end

    assign o_scl_rise = r_scl_rise;
    assign o_scl_fall = r_scl_fall;
    assign o_start    = r_start;
    assign o_stop     = r_stop;
    assign o_sda      = r_sda_smp;

endmodule

// File: rtl/twi_slave.sv
// rtl/twi_slave.sv - I2C target with byte register file shared between bus and host port
module twi_slave
    import twi_slave_pkg::*;
#(
    parameter logic [6:0] SLV_ADDR = 7'h50,
    parameter int         NREG     = 16,
    localparam int        AW       = $clog2(NREG)
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic          SCL_I,
    input  logic          SDA_I,
    output logic          SDA_OEN,
    output logic          BUSY,
    input  logic          HOST_WE,
    input  logic [AW-1:0] HOST_ADR,
    input  logic [7:0]    HOST_DAT_I,
    output logic [7:0]    HOST_DAT_O,
    output logic          WR_STRB,
    output logic [AW-1:0] WR_ADR,
    output logic [7:0]    WR_DAT
);

    logic          w_scl_rise;
    logic          w_scl_fall;
    logic          w_start;
    logic          w_stop;
    logic          w_sda;

    state_e        r_state;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic [AW-1:0] r_ptr;
    logic          r_oen;
    logic          r_busy;
    logic          r_ack_ph;
    logic          r_rw;
    logic          r_wr_strb;
    logic [AW-1:0] r_wr_adr;
    logic [7:0]    r_wr_dat;
    logic [7:0]    r_regs [NREG];

    state_e        w_state_nxt;
    logic [2:0]    w_bitcnt_nxt;
    logic [7:0]    w_shift_nxt;
    logic [AW-1:0] w_ptr_nxt;
    logic          w_oen_nxt;
    logic          w_busy_nxt;
    logic          w_ack_ph_nxt;
    logic          w_rw_nxt;
    logic          w_wr_strb_nxt;
    logic [AW-1:0] w_wr_adr_nxt;
    logic [7:0]    w_wr_dat_nxt;
    logic [7:0]    w_byte;
    logic [7:0]    w_rd_byte;

    twi_line_sync u_sync (
        .CLK_I      (CLK_I),
        .RST_I      (RST_I),
        .i_scl      (SCL_I),
        .i_sda      (SDA_I),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop),
        .o_sda      (w_sda)
    );

    assign w_byte    = {r_shift[6:0], w_sda};
    assign w_rd_byte = r_regs[r_ptr];

    // r_ack_ph splits an ACK slot: clear = before the 9th rise, set = after it.
    always_comb begin
        w_state_nxt   = r_state;
        w_bitcnt_nxt  = r_bitcnt;
        w_shift_nxt   = r_shift;
        w_ptr_nxt     = r_ptr;
        w_oen_nxt     = r_oen;
        w_busy_nxt    = r_busy;
        w_ack_ph_nxt  = r_ack_ph;
        w_rw_nxt      = r_rw;
        w_wr_strb_nxt = 1'b0;
        w_wr_adr_nxt  = r_wr_adr;
        w_wr_dat_nxt  = r_wr_dat;
        if (w_start) begin
            w_state_nxt  = ST_ADDR;
            w_bitcnt_nxt = 3'd0;
            w_oen_nxt    = NACK_LVL;
            w_busy_nxt   = 1'b1;
            w_ack_ph_nxt = 1'b0;
        end else if (w_stop) begin
            w_state_nxt = ST_IDLE;
            w_oen_nxt   = NACK_LVL;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_ADDR, ST_WR_PTR, ST_WR_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt  = w_byte;
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            w_ack_ph_nxt = 1'b0;
                            if (r_state == ST_ADDR) begin
                                w_rw_nxt    = w_byte[0];
                                w_state_nxt = (w_byte[7:1] == SLV_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                            end else if (r_state == ST_WR_PTR) begin
                                w_ptr_nxt   = w_byte[AW-1:0];
                                w_state_nxt = ST_WR_ACK;
                            end else begin
                                w_wr_strb_nxt = 1'b1;
                                w_wr_adr_nxt  = r_ptr;
                                w_wr_dat_nxt  = w_byte;
                                w_ptr_nxt     = r_ptr + AW'(1);
                                w_state_nxt   = ST_WR_ACK;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_WR_ACK: begin
                    if (w_scl_rise) begin
                        w_ack_ph_nxt = 1'b1;
                    end else if (w_scl_fall) begin
                        if (!r_ack_ph) begin
                            w_oen_nxt = ACK_LVL;
                        end else begin
                            w_ack_ph_nxt = 1'b0;
                            w_bitcnt_nxt = 3'd0;
                            if (r_state == ST_ADDR_ACK && r_rw) begin
                                w_state_nxt = ST_RD_DATA;
                                w_shift_nxt = {w_rd_byte[6:0], 1'b1};
                                w_oen_nxt   = w_rd_byte[7];
                            end else begin
                                w_oen_nxt   = NACK_LVL;
                                w_state_nxt = (r_state == ST_ADDR_ACK) ? ST_WR_PTR : ST_WR_DATA;
                            end
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (w_scl_fall) begin
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            w_oen_nxt    = NACK_LVL;
                            w_ack_ph_nxt = 1'b0;
                            w_state_nxt  = ST_RD_ACK;
                        end else begin
                            w_oen_nxt   = r_shift[7];
                            w_shift_nxt = {r_shift[6:0], 1'b1};
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (w_scl_rise) begin
                        w_ptr_nxt = r_ptr + AW'(1);
                        if (w_sda == ACK_LVL) begin
                            w_ack_ph_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_IGNORE;
                        end
                    end else if (w_scl_fall && r_ack_ph) begin
                        w_ack_ph_nxt = 1'b0;
                        w_bitcnt_nxt = 3'd0;
                        w_state_nxt  = ST_RD_DATA;
                        w_shift_nxt  = {w_rd_byte[6:0], 1'b1};
                        w_oen_nxt    = w_rd_byte[7];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_state   <= ST_IDLE;
            r_bitcnt  <= 3'd0;
            r_shift   <= 8'h00;
            r_ptr     <= '0;
            r_oen     <= 1'b1;
            r_busy    <= 1'b0;
            r_ack_ph  <= 1'b0;
            r_rw      <= 1'b0;
            r_wr_strb <= 1'b0;
            r_wr_adr  <= '0;
            r_wr_dat  <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_shift   <= w_shift_nxt;
            r_ptr     <= w_ptr_nxt;
            r_oen     <= w_oen_nxt;
            r_busy    <= w_busy_nxt;
            r_ack_ph  <= w_ack_ph_nxt;
            r_rw      <= w_rw_nxt;
            r_wr_strb <= w_wr_strb_nxt;
            r_wr_adr  <= w_wr_adr_nxt;
            r_wr_dat  <= w_wr_dat_nxt;
        end
    end

    // Bus write lands the cycle after WR_STRB and beats a host write to the same index.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= 8'h00;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (r_wr_strb && r_wr_adr == AW'(i)) begin
                    r_regs[i] <= r_wr_dat;
                end else if (HOST_WE && HOST_ADR == AW'(i)) begin
                    r_regs[i] <= HOST_DAT_I;
                end
            end
        end
    end

    assign SDA_OEN    = r_oen;
    assign BUSY       = r_busy;
    assign HOST_DAT_O = r_regs[HOST_ADR];
    assign WR_STRB    = r_wr_strb;
    assign WR_ADR     = r_wr_adr;
    assign WR_DAT     = r_wr_dat;

endmodule

// File: tb/tb_twi_slave.sv
// tb/tb_twi_slave.sv - bit-banged I2C master bench for twi_slave with a register-file model
module tb_twi_slave;

    localparam logic [6:0] SLV = 7'h50;
    localparam int         Q   = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_line;
    logic        sda_oen;
    logic        busy;
    logic        host_we = 1'b0;
    logic [3:0]  host_adr = 4'd0;
    logic [7:0]  host_dat_i = 8'h00;
    logic [7:0]  host_dat_o;
    logic        wr_strb;
    logic [3:0]  wr_adr;
    logic [7:0]  wr_dat;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          rise_cyc = 0;
    int          fall_cyc = 0;
    int          strb_lat = -1;
    int          oen_lat = -1;
    int          oen_low_cnt = 0;
    logic        prev_oen = 1'b1;

    logic [7:0]  mreg [16];
    int          mptr = 0;
    logic [7:0]  tx_q [$];
    logic [11:0] exp_strb [$];
    logic [11:0] obs_strb [$];

    assign sda_line = sda_m & sda_oen;

    twi_slave dut (
        .CLK_I      (clk),
        .RST_I      (rst),
        .SCL_I      (scl_m),
        .SDA_I      (sda_line),
        .SDA_OEN    (sda_oen),
        .BUSY       (busy),
        .HOST_WE    (host_we),
        .HOST_ADR   (host_adr),
        .HOST_DAT_I (host_dat_i),
        .HOST_DAT_O (host_dat_o),
        .WR_STRB    (wr_strb),
        .WR_ADR     (wr_adr),
        .WR_DAT     (wr_dat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_strb) begin
            obs_strb.push_back({wr_adr, wr_dat});
            strb_lat = cyc - rise_cyc;
        end
        if (!sda_oen && prev_oen) oen_lat = cyc - fall_cyc;
        if (!sda_oen) oen_low_cnt++;
        prev_oen = sda_oen;
    end

    initial begin
        #4ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wq();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic m_bit(input logic v, output logic s);
        sda_m = v;     wq();
        scl_m = 1'b1;  rise_cyc = cyc; wq();
        s = sda_line;  wq();
        scl_m = 1'b0;  fall_cyc = cyc; wq();
    endtask

    task automatic m_start();
        sda_m = 1'b1; scl_m = 1'b1; wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; fall_cyc = cyc; wq();
    endtask

    task automatic m_rstart();
        sda_m = 1'b1; wq();
        scl_m = 1'b1; rise_cyc = cyc; wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; fall_cyc = cyc; wq();
    endtask

    task automatic m_stop();
        sda_m = 1'b0; wq();
        scl_m = 1'b1; rise_cyc = cyc; wq();
        sda_m = 1'b1; wq(); wq();
    endtask

    task automatic m_wbyte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) m_bit(b[i], s);
        m_bit(1'b1, ack);
    endtask

    task automatic m_rbyte(output logic [7:0] b, input logic nack);
        logic s;
        b = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            m_bit(1'b1, s);
            b[i] = s;
        end
        m_bit(nack, s);
    endtask

    // Model: first byte after a matched write address sets ptr, the rest store and advance.
    task automatic bus_write(input logic [7:0] addr, input bit do_stop);
        logic       a;
        logic [7:0] b;
        bit         hit;
        hit = (addr[7:1] == SLV) && !addr[0];
        m_start();
        chk("busy_start", busy, 1);
        m_wbyte(addr, a);
        chk("addr_ack", a, hit ? 0 : 1);
        for (int i = 0; i < tx_q.size(); i++) begin
            b = tx_q[i];
            m_wbyte(b, a);
            chk("data_ack", a, hit ? 0 : 1);
            if (hit) begin
                if (i == 0) begin
                    mptr = int'(b) % 16;
                end else begin
                    mreg[mptr] = b;
                    exp_strb.push_back({4'(mptr), b});
                    mptr = (mptr + 1) % 16;
                end
            end
        end
        if (do_stop) begin
            m_stop();
            chk("busy_stop", busy, 0);
        end
    endtask

    task automatic bus_read(input int n, input bit rs);
        logic       a;
        logic [7:0] b;
        if (rs) m_rstart(); else m_start();
        m_wbyte({SLV, 1'b1}, a);
        chk("rd_addr_ack", a, 0);
        for (int i = 0; i < n; i++) begin
            m_rbyte(b, (i == n - 1));
            chk($sformatf("rd_byte_p%0d", mptr), b, mreg[mptr]);
            mptr = (mptr + 1) % 16;
        end
        m_stop();
        chk("rd_busy_stop", busy, 0);
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        host_we = 1'b1; host_adr = a; host_dat_i = d;
        @(posedge clk); #1;
        host_we = 1'b0;
        mreg[a] = d;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 16; i++) begin
            host_adr = 4'(i);
            #1;
            chk($sformatf("%s_reg%0d", tag, i), host_dat_o, mreg[i]);
        end
    endtask

    task automatic cmp_strb(input string tag);
        chk({tag, "_strb_count"}, obs_strb.size(), exp_strb.size());
        for (int i = 0; i < exp_strb.size() && i < obs_strb.size(); i++)
            chk($sformatf("%s_strb%0d", tag, i), obs_strb[i], exp_strb[i]);
        obs_strb.delete();
        exp_strb.delete();
    endtask

    initial begin
        logic       a;
        logic       s;
        logic [7:0] p;
        logic [7:0] old2;
        int         n;
        int         cnt0;

        for (int i = 0; i < 16; i++) mreg[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_oen", sda_oen, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wr_strb", wr_strb, 0);
        chk("rst_wr_adr", wr_adr, 0);
        chk("rst_wr_dat", wr_dat, 0);
        check_regs("rst");

        // write burst
        tx_q = '{8'h03, 8'h11, 8'h22};
        bus_write(8'hA0, 1'b1);
        chk("burst_strb_lat", strb_lat, 4);
        chk("burst_oen_lat", oen_lat, 4);
        cmp_strb("burst");
        check_regs("burst");

        // read with repeated start, then pointer continuation
        host_write(4'd5, 8'h5A);
        host_write(4'd6, 8'hC3);
        host_write(4'd7, 8'($urandom_range(1, 255)));
        tx_q = '{8'h05};
        bus_write(8'hA0, 1'b0);
        bus_read(2, 1'b1);
        chk("ptr_after_read", mptr, 7);
        bus_read(1, 1'b0);

        // address mismatch
        cnt0 = oen_low_cnt;
        tx_q = '{8'hFF};
        bus_write(8'hA2, 1'b1);
        chk("mismatch_oen_low_cycles", oen_low_cnt - cnt0, 0);
        cmp_strb("mismatch");
        check_regs("mismatch");

        // pointer wrap and pointer upper-bit discard
        tx_q = '{8'h0F, 8'hAA, 8'hBB};
        bus_write(8'hA0, 1'b1);
        tx_q = '{8'h13, 8'h6D};
        bus_write(8'hA0, 1'b1);
        cmp_strb("wrap");
        check_regs("wrap");

        // collision: host hits the bus index (bus wins), then a different index (host lands)
        old2 = mreg[2];
        tx_q = '{8'h02, 8'h99, 8'h5E};
        fork
            bus_write(8'hA0, 1'b1);
            begin : host_side
                bit seen;
                for (int st = 0; st < 2; st++) begin
                    seen = 1'b0;
                    for (int k = 0; k < 3000 && !seen; k++) begin
                        @(posedge clk); #1;
                        if (wr_strb) seen = 1'b1;
                    end
                    chk($sformatf("coll_strobe_seen%0d", st), seen, 1);
                    if (seen) begin
                        host_we    = 1'b1;
                        host_adr   = (st == 0) ? 4'd2 : 4'd9;
                        host_dat_i = (st == 0) ? 8'h77 : 8'h44;
                        #1;
                        if (st == 0) chk("coll_pre_visible", host_dat_o, old2);
                        @(posedge clk); #1;
                        host_we = 1'b0;
                        if (st == 0) chk("coll_post_visible", host_dat_o, 8'h99);
                    end
                end
            end
        join
        mreg[9] = 8'h44;
        cmp_strb("coll");
        check_regs("coll");

        // randomized transactions against the model
        for (int it = 0; it < 6; it++) begin
            host_write(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            p = 8'($urandom_range(0, 255));
            n = $urandom_range(1, 4);
            tx_q = '{p};
            for (int j = 0; j < n; j++) tx_q.push_back(8'($urandom_range(0, 255)));
            if (it == 2) bus_write({SLV ^ 7'(1 << $urandom_range(0, 6)), 1'b0}, 1'b1);
            else         bus_write({SLV, 1'b0}, 1'b1);
            cmp_strb($sformatf("rnd%0d", it));
            tx_q = '{p};
            bus_write({SLV, 1'b0}, 1'b0);
            bus_read(n, 1'b1);
        end
        check_regs("rnd");

        // reset during bit 4 of a read byte with SDA driven low
        host_write(4'd1, 8'hE5);
        tx_q = '{8'h01};
        bus_write(8'hA0, 1'b0);
        m_rstart();
        m_wbyte({SLV, 1'b1}, a);
        chk("rr_addr_ack", a, 0);
        for (int i = 7; i >= 5; i--) begin
            m_bit(1'b1, s);
            chk($sformatf("rr_bit%0d", i), s, 1);
        end
        chk("rr_bit4_driven_low", sda_oen, 0);
        #3;
        rst = 1'b1;
        #1;
        chk("rr_oen_released", sda_oen, 1);
        chk("rr_busy_clear", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) mreg[i] = 8'h00;
        mptr = 0;
        obs_strb.delete();
        exp_strb.delete();
        sda_m = 1'b1;
        m_stop();
        tx_q = '{8'h01, 8'h3C};
        bus_write(8'hA0, 1'b1);
        tx_q = '{8'h01};
        bus_write(8'hA0, 1'b0);
        bus_read(1, 1'b1);
        cmp_strb("rr");
        check_regs("rr");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
